// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default sizes for the two-port external memory bus arbiter.
// The tie-break policy switch (MEM_ARB_FIXED_PRIO_EN) lives in mem_rr_picker.
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 15;
    localparam int DATA_W_DEF   = 8;
    localparam int READ_LAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_WDATA = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic owner_t;

    localparam owner_t OWNER_M0 = 1'b0;
    localparam owner_t OWNER_M1 = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and pin-side signals of the memory bus arbiter.
// The slave modport is the arbiter's view; master is the requesters/pins view.
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_done;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_done;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ext_req_bus;
    logic              ext_write_req;
    logic [DATA_W-1:0] ext_read_bus;
    logic              busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  ext_read_bus,
        output m0_done, m1_done, rdata, ext_req_bus, ext_write_req, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output ext_read_bus,
        input  m0_done, m1_done, rdata, ext_req_bus, ext_write_req, busy
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational two-way request picker. MEM_ARB_FIXED_PRIO_EN defined: port 0 always
// wins ties; undefined (default): the port that did not win last time wins ties.
module mem_rr_picker
    import mem_arb_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_t last_gnt,
    output owner_t gnt,
    output logic   any
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    // Fixed priority: port 0 whenever it asks.
    always_comb begin
        any = req0 | req1;
        if (req0) begin
            gnt = OWNER_M0;
        end else if (req1) begin
            gnt = OWNER_M1;
        end else begin
            gnt = OWNER_M0;
        end
    end
`else
    // Round-robin: a tie goes to the port that was not granted last.
    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            gnt = ~last_gnt;
        end else if (req1) begin
            gnt = OWNER_M1;
        end else begin
            gnt = OWNER_M0;
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the narrow external memory bus between the CPU (port 0) and the loader (port 1).
// Tie-break policy is chosen by MEM_ARB_FIXED_PRIO_EN in mem_rr_picker (round-robin when undefined).
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus
);

    localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

    state_t            state_r, state_s;
    logic [2:0]        cnt_r, cnt_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    owner_t            owner_r, owner_s;
    owner_t            last_gnt_r, last_gnt_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic [ADDR_W-1:0] ext_req_bus_r, ext_req_bus_s;
    logic              ext_write_req_r, ext_write_req_s;
    logic              m0_done_r, m0_done_s;
    logic              m1_done_r, m1_done_s;
    logic              busy_r, busy_s;
    owner_t            gnt_s;
    logic              any_s;

    mem_rr_picker u_picker (
        .req0     (bus.m0_req),
        .req1     (bus.m1_req),
        .last_gnt (last_gnt_r),
        .gnt      (gnt_s),
        .any      (any_s)
    );

    // Next state and transaction latch; requests are only sampled in IDLE.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        we_s       = we_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        owner_s    = owner_r;
        last_gnt_s = last_gnt_r;
        rdata_s    = rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_s    = ST_ADDR;
                    cnt_s      = 3'd0;
                    owner_s    = gnt_s;
                    last_gnt_s = gnt_s;
                    if (gnt_s == OWNER_M1) begin
                        we_s    = bus.m1_we;
                        addr_s  = bus.m1_addr;
                        wdata_s = bus.m1_wdata;
                    end else begin
                        we_s    = bus.m0_we;
                        addr_s  = bus.m0_addr;
                        wdata_s = bus.m0_wdata;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (we_r) begin
                    state_s = ST_WDATA;
                end else if (cnt_r == LAT_LAST) begin
                    // Last address cycle of a read: the edge ending it captures the pins.
                    state_s = ST_DONE;
                    rdata_s = bus.ext_read_bus;
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            ST_WDATA: state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Pin values for the state being entered, so every output comes straight from a flop.
    always_comb begin
        ext_req_bus_s   = '0;
        ext_write_req_s = 1'b0;
        m0_done_s       = 1'b0;
        m1_done_s       = 1'b0;
        busy_s          = (state_s != ST_IDLE);
        case (state_s)
            ST_ADDR: ext_req_bus_s = addr_s;
            ST_WDATA: begin
                ext_req_bus_s   = ADDR_W'(wdata_s);
                ext_write_req_s = 1'b1;
            end
            ST_DONE: begin
                m0_done_s = (owner_s == OWNER_M0);
                m1_done_s = (owner_s == OWNER_M1);
            end
            default: ext_req_bus_s = '0;
        endcase
    end

    // State, latched transaction and registered pin drivers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            cnt_r           <= 3'd0;
            we_r            <= 1'b0;
            addr_r          <= '0;
            wdata_r         <= '0;
            owner_r         <= OWNER_M0;
            last_gnt_r      <= OWNER_M1;
            rdata_r         <= '0;
            ext_req_bus_r   <= '0;
            ext_write_req_r <= 1'b0;
            m0_done_r       <= 1'b0;
            m1_done_r       <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_s;
            cnt_r           <= cnt_s;
            we_r            <= we_s;
            addr_r          <= addr_s;
            wdata_r         <= wdata_s;
            owner_r         <= owner_s;
            last_gnt_r      <= last_gnt_s;
            rdata_r         <= rdata_s;
            ext_req_bus_r   <= ext_req_bus_s;
            ext_write_req_r <= ext_write_req_s;
            m0_done_r       <= m0_done_s;
            m1_done_r       <= m1_done_s;
            busy_r          <= busy_s;
        end
    end

    assign bus.ext_req_bus   = ext_req_bus_r;
    assign bus.ext_write_req = ext_write_req_r;
    assign bus.m0_done       = m0_done_r;
    assign bus.m1_done       = m1_done_r;
    assign bus.rdata         = rdata_r;
    assign bus.busy          = busy_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a timeline model of each accepted transaction checks the
// READ_LAT=2 instance every cycle; two extra instances pin READ_LAT=1 and READ_LAT=7.
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int AW  = 15;
    localparam int DW  = 8;
    localparam int LAT = 2;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_l1 ();
    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_l7 ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut_l1 (.clk(clk), .reset(reset), .bus(bus_l1.slave));
    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(7)) dut_l7 (.clk(clk), .reset(reset), .bus(bus_l7.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one active transaction at most, described by its accept cycle t0.
    int                cyc = 0;
    bit                act = 1'b0;
    int                t0 = 0;
    bit                own, mwe;
    logic [AW-1:0]     maddr;
    logic [DW-1:0]     mwdata;
    bit                m_last = 1'b1;
    logic [DW-1:0]     m_rdata = '0;
    bit                exp_done0 = 1'b0, exp_done1 = 1'b0;

    always @(negedge clk) begin
        int k, end_k;
        logic [AW-1:0] e_bus;
        bit e_wr, e_d0, e_d1, w;
        if (reset) begin
            act = 1'b0; m_last = 1'b1; m_rdata = '0; exp_done0 = 1'b0; exp_done1 = 1'b0;
        end else begin
            e_bus = '0; e_wr = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
            k = cyc - t0;
            end_k = mwe ? 3 : LAT + 1;
            if (act) begin
                if (k >= 1 && k <= (mwe ? 1 : LAT)) e_bus = maddr;
                if (mwe && k == 2) begin e_bus = AW'(mwdata); e_wr = 1'b1; end
                if (k == end_k) begin
                    if (own) e_d1 = 1'b1;
                    else e_d0 = 1'b1;
                end
            end
            chk("m_bus", 32'(bus.ext_req_bus), 32'(e_bus));
            chk("m_wr", 32'(bus.ext_write_req), 32'(e_wr));
            chk("m_done0", 32'(bus.m0_done), 32'(e_d0));
            chk("m_done1", 32'(bus.m1_done), 32'(e_d1));
            chk("m_busy", 32'(bus.busy), 32'(act));
            chk("m_rdata", 32'(bus.rdata), 32'(m_rdata));
            exp_done0 = e_d0;
            exp_done1 = e_d1;
            if (act && !mwe && k == LAT) m_rdata = bus.ext_read_bus;
            if (act) begin
                if (k == end_k) act = 1'b0;
            end else if (bus.m0_req || bus.m1_req) begin
                if (bus.m0_req && bus.m1_req) w = FIXED ? 1'b0 : !m_last;
                else w = bus.m1_req;
                own = w; m_last = w; act = 1'b1; t0 = cyc;
                mwe    = w ? bus.m1_we : bus.m0_we;
                maddr  = w ? bus.m1_addr : bus.m0_addr;
                mwdata = w ? bus.m1_wdata : bus.m0_wdata;
            end
        end
        cyc++;
    end

    task automatic start_req(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p) begin bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; end
        else   begin bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; end
    endtask

    // Both latency probes get the same port-0 request; each drops it after its own done.
    task automatic probe_lat(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW-1:0] rd, output int n1, output int n7);
        @(posedge clk); #1;
        bus_l1.m0_req = 1'b1; bus_l1.m0_we = we; bus_l1.m0_addr = a; bus_l1.m0_wdata = d; bus_l1.ext_read_bus = rd;
        bus_l7.m0_req = 1'b1; bus_l7.m0_we = we; bus_l7.m0_addr = a; bus_l7.m0_wdata = d; bus_l7.ext_read_bus = rd;
        n1 = -1; n7 = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus_l1.m0_done && n1 < 0) n1 = n;
            if (bus_l7.m0_done && n7 < 0) n7 = n;
            @(posedge clk); #1;
            if (n1 >= 0) bus_l1.m0_req = 1'b0;
            if (n7 >= 0) bus_l7.m0_req = 1'b0;
        end
    endtask

    task automatic rand_phase(input int ncyc);
        bit pend[2]; bit rq[2]; bit w[2];
        logic [AW-1:0] a[2]; logic [DW-1:0] d[2];
        bit dn, fl;
        for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; rq[p] = 1'b0; w[p] = 1'b0; a[p] = '0; d[p] = '0; end
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            bus.ext_read_bus = DW'($urandom);
            for (int p = 0; p < 2; p++) begin
                dn = (p == 1) ? exp_done1 : exp_done0;
                fl = act && (own == (p == 1));
                if (dn) begin pend[p] = 1'b0; rq[p] = 1'b0; end
                if (!pend[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[p] = 1'b1; rq[p] = 1'b1; w[p] = 1'($urandom_range(0, 1));
                        a[p] = AW'($urandom); d[p] = DW'($urandom);
                    end
                end else if (fl) begin
                    if ($urandom_range(0, 7) == 0) begin a[p] = AW'($urandom); d[p] = DW'($urandom); w[p] = ~w[p]; end
                    if ($urandom_range(0, 15) == 0) rq[p] = 1'b0;
                end
            end
            bus.m0_req = rq[0]; bus.m0_we = w[0]; bus.m0_addr = a[0]; bus.m0_wdata = d[0];
            bus.m1_req = rq[1]; bus.m1_we = w[1]; bus.m1_addr = a[1]; bus.m1_wdata = d[1];
        end
        @(posedge clk); #1;
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    endtask

    initial begin
        int n1, n7, ndone;
        int order[4];
        reset = 1'b1;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.ext_read_bus = '0;
        bus_l1.m0_req = 1'b0; bus_l1.m0_we = 1'b0; bus_l1.m0_addr = '0; bus_l1.m0_wdata = '0;
        bus_l1.m1_req = 1'b0; bus_l1.m1_we = 1'b0; bus_l1.m1_addr = '0; bus_l1.m1_wdata = '0;
        bus_l1.ext_read_bus = '0;
        bus_l7.m0_req = 1'b0; bus_l7.m0_we = 1'b0; bus_l7.m0_addr = '0; bus_l7.m0_wdata = '0;
        bus_l7.m1_req = 1'b0; bus_l7.m1_we = 1'b0; bus_l7.m1_addr = '0; bus_l7.m1_wdata = '0;
        bus_l7.ext_read_bus = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_bus", 32'(bus.ext_req_bus), 32'h0);
        chk("rst_rdata", 32'(bus.rdata), 32'h0);
        reset = 1'b0;

        // m0 read of 0x1234 returning 0xA5
        @(posedge clk); #1;
        start_req(1'b0, 1'b0, 15'h1234, 8'h00); bus.ext_read_bus = 8'hA5;
        @(negedge clk); chk("t1_idle", 32'(bus.busy), 32'h0);
        @(negedge clk); chk("t1_a1", 32'(bus.ext_req_bus), 32'h1234);
        @(negedge clk); chk("t1_a2", 32'(bus.ext_req_bus), 32'h1234);
        @(negedge clk); chk("t1_done", 32'(bus.m0_done), 32'h1); chk("t1_rdata", 32'(bus.rdata), 32'hA5);
        @(posedge clk); #1; bus.m0_req = 1'b0;

        // m1 write of 0x3C to 0x7FFF
        start_req(1'b1, 1'b1, 15'h7FFF, 8'h3C);
        @(negedge clk);
        @(negedge clk); chk("t2_addr", 32'(bus.ext_req_bus), 32'h7FFF); chk("t2_wr0", 32'(bus.ext_write_req), 32'h0);
        @(negedge clk); chk("t2_data", 32'(bus.ext_req_bus), 32'h003C); chk("t2_wr1", 32'(bus.ext_write_req), 32'h1);
        @(negedge clk); chk("t2_done", 32'(bus.m1_done), 32'h1); chk("t2_rdata", 32'(bus.rdata), 32'hA5);
        @(posedge clk); #1; bus.m1_req = 1'b0;

        // both ports hold read requests continuously
        start_req(1'b0, 1'b0, 15'h0100, 8'h00);
        start_req(1'b1, 1'b0, 15'h0200, 8'h00);
        ndone = 0;
        for (int n = 0; n < 40 && ndone < 4; n++) begin
            @(negedge clk);
            if (bus.m0_done) begin order[ndone] = 0; ndone++; end
            else if (bus.m1_done) begin order[ndone] = 1; ndone++; end
        end
        @(posedge clk); #1; bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        chk("t3_count", 32'(ndone), 32'd4);
        if (ndone == 4) begin
            for (int i = 0; i < 4; i++) chk("t3_order", 32'(order[i]), FIXED ? 32'd0 : 32'(i % 2));
        end

        // m0 write whose request and address change once accepted
        start_req(1'b0, 1'b1, 15'h0ABC, 8'h11);
        @(posedge clk); #1; bus.m0_req = 1'b0; bus.m0_addr = 15'h0000;
        @(negedge clk); chk("t4_addr", 32'(bus.ext_req_bus), 32'h0ABC);
        @(negedge clk); chk("t4_data", 32'(bus.ext_req_bus), 32'h0011); chk("t4_wr", 32'(bus.ext_write_req), 32'h1);
        @(negedge clk); chk("t4_done", 32'(bus.m0_done), 32'h1);
        @(posedge clk); #1;

        // reset in the middle of a read wait
        start_req(1'b0, 1'b0, 15'h0555, 8'h00); bus.ext_read_bus = 8'h66;
        @(posedge clk); #2; reset = 1'b1; #1;
        chk("t5_busy", 32'(bus.busy), 32'h0);
        chk("t5_bus", 32'(bus.ext_req_bus), 32'h0);
        chk("t5_wr", 32'(bus.ext_write_req), 32'h0);
        chk("t5_done", 32'(bus.m0_done), 32'h0);
        bus.m0_req = 1'b0;
        @(posedge clk); #2; reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk); chk("t5_nodone", 32'(bus.m0_done), 32'h0);
        end
        @(posedge clk); #1;
        start_req(1'b0, 1'b0, 15'h0100, 8'h00); bus.ext_read_bus = 8'h77;
        repeat (4) @(negedge clk);
        chk("t5_redone", 32'(bus.m0_done), 32'h1); chk("t5_rdata", 32'(bus.rdata), 32'h77);
        @(posedge clk); #1; bus.m0_req = 1'b0;

        // READ_LAT 1 and 7 instances
        probe_lat(1'b0, 15'h0042, 8'h00, 8'h5A, n1, n7);
        chk("l1_rd_lat", 32'(n1), 32'd2); chk("l7_rd_lat", 32'(n7), 32'd8);
        chk("l1_rdata", 32'(bus_l1.rdata), 32'h5A); chk("l7_rdata", 32'(bus_l7.rdata), 32'h5A);
        probe_lat(1'b1, 15'h0022, 8'h99, 8'hEE, n1, n7);
        chk("l1_wr_lat", 32'(n1), 32'd3); chk("l7_wr_lat", 32'(n7), 32'd3);
        chk("l1_hold", 32'(bus_l1.rdata), 32'h5A); chk("l7_hold", 32'(bus_l7.rdata), 32'h5A);
        probe_lat(1'b0, 15'h0043, 8'h00, 8'hC3, n1, n7);
        chk("l1_rdata2", 32'(bus_l1.rdata), 32'hC3); chk("l7_rdata2", 32'(bus_l7.rdata), 32'hC3);
        chk("l_idle", 32'({bus_l1.busy, bus_l7.busy, bus_l1.ext_write_req, bus_l7.ext_write_req,
                           bus_l1.m1_done, bus_l7.m1_done}), 32'h0);
        chk("l_bus", 32'(bus_l1.ext_req_bus | bus_l7.ext_req_bus), 32'h0);

        rand_phase(3000);
        repeat (12) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
